// File: rtl/cic_pkg.sv
// Shared CIC decimator definitions: filter output width, buffered sample width
// and the capture-timer state encoding.
package cic_pkg;

  localparam int CIC_WIDTH     = 25;
  localparam int CIC_OUT_WIDTH = 16;

  typedef logic signed [CIC_WIDTH-1:0] cic_sample_t;

  typedef enum logic {
    TMR_IDLE,
    TMR_COUNT
  } tmr_state_e;

endpackage

// File: rtl/cic_sample_fifo.sv
// Synchronous show-ahead FIFO: head word is visible on rdata_o while non-empty,
// and reads as zero when empty. A pop on a full FIFO frees the slot for a same-cycle push.
module cic_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cic_sample_buffer.sv
// CIC output stage: times a capture after each divided_clk rise, rescales the
// sample (shift, optional round-half-up, saturate) and queues it for readout.
module cic_sample_buffer
  import cic_pkg::*;
#(
  parameter int IN_WIDTH      = CIC_WIDTH,
  parameter int OUT_WIDTH     = CIC_OUT_WIDTH,
  parameter int DEPTH         = 8,
  parameter int CAPTURE_DELAY = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        divided_clk,
  input  logic signed [IN_WIDTH-1:0]  sample_in,
  input  logic                        enable,
  input  logic [3:0]                  shift_sel,
  input  logic                        round_en,
  output logic [OUT_WIDTH-1:0]        dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [$clog2(DEPTH+1)-1:0]  fill_level,
  output logic                        overflow,
  input  logic                        overflow_clr
);

  localparam int MAX_SHIFT = IN_WIDTH - OUT_WIDTH;
  localparam logic signed [IN_WIDTH:0] SAT_MAX =
    $signed((IN_WIDTH+1)'((64'd1 << (OUT_WIDTH-1)) - 64'd1));
  localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

  logic                       div_q;
  logic                       rise;
  tmr_state_e                 state_q, state_d;
  logic [3:0]                 count_q, count_d;
  logic                       push;
  logic                       overflow_q, overflow_d;
  logic                       fifo_full, fifo_empty, pop;

  logic [3:0]                 shift_eff;
  logic [IN_WIDTH:0]          round_add;
  logic signed [IN_WIDTH:0]   x_wide, y_wide;
  logic [OUT_WIDTH-1:0]       scaled;

  assign rise = divided_clk & ~div_q;

  // A rise always (re)starts the timer; a pending capture is then abandoned.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    push    = 1'b0;
    if (!enable) begin
      state_d = TMR_IDLE;
      count_d = '0;
    end else if (rise) begin
      if (CAPTURE_DELAY == 0) begin
        push    = 1'b1;
        state_d = TMR_IDLE;
        count_d = '0;
      end else begin
        state_d = TMR_COUNT;
        count_d = 4'(CAPTURE_DELAY);
      end
    end else if (state_q == TMR_COUNT) begin
      if (count_q == 4'd1) begin
        push    = 1'b1;
        state_d = TMR_IDLE;
        count_d = '0;
      end else begin
        count_d = count_q - 4'd1;
      end
    end
  end

  always_comb begin
    shift_eff = (int'(shift_sel) > MAX_SHIFT) ? 4'(MAX_SHIFT) : shift_sel;
    round_add = (round_en && shift_eff != 4'd0) ?
                ((IN_WIDTH+1)'(1) << (shift_eff - 4'd1)) : '0;
    // One guard bit keeps the rounding add from wrapping at full scale.
    x_wide    = $signed({sample_in[IN_WIDTH-1], sample_in}) + $signed(round_add);
    y_wide    = x_wide >>> shift_eff;
    if (y_wide > SAT_MAX)      scaled = SAT_MAX[OUT_WIDTH-1:0];
    else if (y_wide < SAT_MIN) scaled = SAT_MIN[OUT_WIDTH-1:0];
    else                       scaled = y_wide[OUT_WIDTH-1:0];
  end

  assign pop = dout_valid & dout_ready;

  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr)                   overflow_d = 1'b0;
    if (push && fifo_full && !pop)      overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= 1'b0;
      state_q    <= TMR_IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      div_q      <= divided_clk;
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  cic_sample_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .wdata_i (scaled),
    .pop_i   (pop),
    .rdata_o (dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fill_level)
  );

  assign dout_valid = ~fifo_empty;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_cic_sample_buffer.sv
// Directed bench for cic_sample_buffer: capture timing, scaling, saturation,
// FIFO overflow, simultaneous push/pop, enable gating and mid-run reset.
module tb_cic_sample_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        divided_clk;
  logic [24:0] sample_in;
  logic        enable;
  logic [3:0]  shift_sel;
  logic        round_en;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [3:0]  fill_level;
  logic        overflow;
  logic        overflow_clr;

  int total = 0;
  int bad   = 0;

  cic_sample_buffer #(
    .IN_WIDTH(25), .OUT_WIDTH(16), .DEPTH(8), .CAPTURE_DELAY(2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .divided_clk  (divided_clk),
    .sample_in    (sample_in),
    .enable       (enable),
    .shift_sel    (shift_sel),
    .round_en     (round_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .fill_level   (fill_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded, got timeout want finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Rise on divided_clk, held high through the push cycle, then low one cycle.
  task automatic capture(input logic [24:0] v);
    sample_in   = v;
    divided_clk = 1'b1;
    tick(3);
    divided_clk = 1'b0;
    tick(1);
  endtask

  task automatic pop_one();
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; divided_clk = 1'b0; sample_in = '0; enable = 1'b0;
    shift_sel = 4'd0; round_en = 1'b0; dout_ready = 1'b0; overflow_clr = 1'b0;
    tick(3);
    total++;
    if (dout !== 16'h0 || dout_valid !== 1'b0 || fill_level !== 4'd0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got dout=%h valid=%b fill=%0d ovf=%b want 0/0/0/0",
               dout, dout_valid, fill_level, overflow);
    end
    reset_n = 1'b1;
    enable  = 1'b1;
    tick(2);
    $display("reset: dout=%h valid=%b fill=%0d", dout, dout_valid, fill_level);
  endtask

  task automatic test_capture_timing();
    sample_in   = 25'h0001234;
    divided_clk = 1'b1;
    tick(2);
    total++;
    if (dout_valid !== 1'b0 || fill_level !== 4'd0) begin
      bad++;
      $display("FAIL capture_early: got valid=%b fill=%0d want 0/0", dout_valid, fill_level);
    end
    tick(1);
    total++;
    if (dout_valid !== 1'b1 || dout !== 16'h1234 || fill_level !== 4'd1) begin
      bad++;
      $display("FAIL capture_first: got valid=%b dout=%h fill=%0d want 1/1234/1",
               dout_valid, dout, fill_level);
    end
    tick(125);
    divided_clk = 1'b0;
    tick(128);
    total++;
    if (fill_level !== 4'd1) begin
      bad++;
      $display("FAIL capture_once: got fill=%0d want 1", fill_level);
    end
    divided_clk = 1'b1;
    tick(3);
    total++;
    if (fill_level !== 4'd2 || dout !== 16'h1234) begin
      bad++;
      $display("FAIL capture_second: got fill=%0d dout=%h want 2/1234", fill_level, dout);
    end
    tick(125);
    divided_clk = 1'b0;
    tick(1);
    pop_one();
    pop_one();
    total++;
    if (fill_level !== 4'd0 || dout !== 16'h0 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL capture_drain: got fill=%0d dout=%h valid=%b want 0/0000/0",
               fill_level, dout, dout_valid);
    end
    $display("capture_timing: two captures at clk/256 drained");
  endtask

  task automatic test_scaling();
    logic [24:0] s_v [20] = '{25'd767, 25'd767, 25'h1FFFF00, 25'd767, 25'd255,
                              25'd256, 25'd511, 25'd511, 25'h1238, 25'h1238,
                              25'h1FFFEFF, 25'h0FFFFFF, 25'h1000000, 25'h0007FFF, 25'h0008000,
                              25'h1FF8000, 25'h1FF7FFF, 25'h0FFFFFF, 25'h1000000, 25'h0000200};
    logic [3:0]  sh_v [20] = '{4'd9, 4'd9, 4'd9, 4'd15, 4'd9, 4'd9, 4'd9, 4'd9, 4'd4, 4'd4,
                               4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd9, 4'd12};
    logic        rn_v [20] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] ex_v [20] = '{16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0000,
                               16'h0001, 16'h0000, 16'h0001, 16'h0124, 16'h0123,
                               16'hFFFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF,
                               16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 16'h0001};
    for (int i = 0; i < 20; i++) begin
      shift_sel = sh_v[i];
      round_en  = rn_v[i];
      capture(s_v[i]);
      total++;
      if (dout_valid !== 1'b1 || dout !== ex_v[i]) begin
        bad++;
        $display("FAIL scale_%0d: in=%h sh=%0d rnd=%b got valid=%b dout=%h want 1/%h",
                 i, s_v[i], sh_v[i], rn_v[i], dout_valid, dout, ex_v[i]);
      end else begin
        $display("scale_%0d: in=%h sh=%0d rnd=%b dout=%h", i, s_v[i], sh_v[i], rn_v[i], dout);
      end
      pop_one();
    end
    shift_sel = 4'd0;
    round_en  = 1'b0;
    total++;
    if (fill_level !== 4'd0) begin
      bad++;
      $display("FAIL scale_drain: got fill=%0d want 0", fill_level);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      capture(25'(i + 1));
      if (i == 7) begin
        total++;
        if (fill_level !== 4'd8 || overflow !== 1'b0) begin
          bad++;
          $display("FAIL ovf_full: got fill=%0d ovf=%b want 8/0", fill_level, overflow);
        end
      end
    end
    total++;
    if (fill_level !== 4'd8 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_drop: got fill=%0d ovf=%b want 8/1", fill_level, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dout !== 16'(i + 1) || dout_valid !== 1'b1) begin
        bad++;
        $display("FAIL ovf_read_%0d: got dout=%h valid=%b want %h/1", i, dout, dout_valid, 16'(i + 1));
      end
      pop_one();
    end
    total++;
    if (fill_level !== 4'd0 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: got fill=%0d ovf=%b want 0/1", fill_level, overflow);
    end
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: got ovf=%b want 0", overflow);
    end
    $display("overflow: 9 captures, 8 kept, flag cleared");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) capture(25'(16'h10 + i));
    sample_in   = 25'h99;
    divided_clk = 1'b1;
    tick(2);
    dout_ready  = 1'b1;
    tick(1);
    dout_ready  = 1'b0;
    divided_clk = 1'b0;
    total++;
    if (fill_level !== 4'd8 || overflow !== 1'b0 || dout !== 16'h0011) begin
      bad++;
      $display("FAIL b2b_same_cycle: got fill=%0d ovf=%b dout=%h want 8/0/0011",
               fill_level, overflow, dout);
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] exp_v;
      exp_v = (i < 7) ? 16'(16'h11 + i) : 16'h0099;
      total++;
      if (dout !== exp_v) begin
        bad++;
        $display("FAIL b2b_read_%0d: got dout=%h want %h", i, dout, exp_v);
      end
      pop_one();
    end
    total++;
    if (fill_level !== 4'd0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: got fill=%0d ovf=%b want 0/0", fill_level, overflow);
    end
    $display("back_to_back: push+pop on full kept order");
  endtask

  task automatic test_enable_reset();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) capture(25'h00ABC);
    total++;
    if (fill_level !== 4'd0 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL enable_off: got fill=%0d valid=%b want 0/0", fill_level, dout_valid);
    end
    // enable dropped while the timer is running cancels the capture
    enable      = 1'b1;
    divided_clk = 1'b1;
    tick(1);
    enable      = 1'b0;
    tick(3);
    divided_clk = 1'b0;
    enable      = 1'b1;
    tick(1);
    total++;
    if (fill_level !== 4'd0) begin
      bad++;
      $display("FAIL enable_cancel: got fill=%0d want 0", fill_level);
    end
    for (int i = 0; i < 5; i++) capture(25'(16'h200 + i));
    total++;
    if (fill_level !== 4'd5 || dout !== 16'h0200) begin
      bad++;
      $display("FAIL pre_reset: got fill=%0d dout=%h want 5/0200", fill_level, dout);
    end
    divided_clk = 1'b1;
    tick(1);
    reset_n     = 1'b0;
    divided_clk = 1'b0;
    #2;
    total++;
    if (fill_level !== 4'd0 || dout !== 16'h0 || dout_valid !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got fill=%0d dout=%h valid=%b ovf=%b want 0/0000/0/0",
               fill_level, dout, dout_valid, overflow);
    end
    tick(1);
    reset_n = 1'b1;
    tick(4);
    total++;
    if (fill_level !== 4'd0 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_discard: got fill=%0d valid=%b want 0/0", fill_level, dout_valid);
    end
    $display("enable_reset: gated captures, flushed by reset");
  endtask

  initial begin
    test_reset();
    test_capture_timing();
    test_scaling();
    test_overflow();
    test_back_to_back();
    test_enable_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
